// File: rtl/svetofor_phase_monitor_pkg.sv
// Shared phase codes, fault codes and lamp patterns for the stoplight
// controller, the phase monitor and its bench.
package svetofor_phase_monitor_pkg;

  typedef enum logic [2:0] {
    PH_SYNC   = 3'd0,
    PH_RED    = 3'd1,
    PH_REDYEL = 3'd2,
    PH_GREEN  = 3'd3,
    PH_BLINK  = 3'd4,
    PH_YELLOW = 3'd5,
    PH_FAULT  = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_PATTERN = 3'd1,
    FC_TRANS   = 3'd2,
    FC_SHORT   = 3'd3,
    FC_LONG    = 3'd4
  } fcode_e;

  // Lamp patterns as {green,yellow,red}, active-low
  localparam logic [2:0] LAMP_RED    = 3'b110;
  localparam logic [2:0] LAMP_REDYEL = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b011;
  localparam logic [2:0] LAMP_OFF    = 3'b111;
  localparam logic [2:0] LAMP_YELLOW = 3'b101;

  localparam logic [7:0] DEF_RED_TICKS    = 8'd168;
  localparam logic [7:0] DEF_REDYEL_TICKS = 8'd6;
  localparam logic [7:0] DEF_GREEN_TICKS  = 8'd52;
  localparam logic [7:0] DEF_BLINK_TICKS  = 8'd8;
  localparam logic [7:0] DEF_YELLOW_TICKS = 8'd6;
  localparam logic [7:0] DEF_TOL          = 8'd2;

  function automatic logic lamp_legal(
    input logic [2:0] l
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (l == LAMP_RED):    ok = 1'b1;
      (l == LAMP_REDYEL): ok = 1'b1;
      (l == LAMP_GREEN):  ok = 1'b1;
      (l == LAMP_OFF):    ok = 1'b1;
      (l == LAMP_YELLOW): ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/svetofor_phase_monitor_if.sv
// Lamp inputs, fault clear and decoded status of the phase monitor.
// master = controller/observer side, slave = monitor.
interface svetofor_phase_monitor_if;

  logic        red;
  logic        yellow;
  logic        green;
  logic        fault_clr;
  logic [2:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  dwell;
  logic [15:0] cycle_count;
  logic        ped_walk;
  logic        ped_stop;

  modport master (
    output red,
    output yellow,
    output green,
    output fault_clr,
    input  phase,
    input  fault,
    input  fault_code,
    input  dwell,
    input  cycle_count,
    input  ped_walk,
    input  ped_stop
  );

  modport slave (
    input  red,
    input  yellow,
    input  green,
    input  fault_clr,
    output phase,
    output fault,
    output fault_code,
    output dwell,
    output cycle_count,
    output ped_walk,
    output ped_stop
  );

endinterface

// File: rtl/svetofor_dwell_timer.sv
// Saturating 8-bit dwell counter with clear/restart/hold controls and
// short/long flags against an expected dwell +/- tolerance.
module svetofor_dwell_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       restart_i,
  input  logic       hold_i,
  input  logic [7:0] exp_i,
  input  logic [7:0] tol_i,
  output logic [7:0] cnt_o,
  output logic       short_o,
  output logic       long_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic [8:0] lo;
  logic [8:0] hi;

  always_comb begin
    cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    hi = {1'b0, exp_i} + {1'b0, tol_i};
    lo = (exp_i < tol_i) ? 9'd0
                         : {1'b0, exp_i} - {1'b0, tol_i};
  end

  // long looks at the value the counter is about to take, so the
  // fault lands on the very tick the limit is crossed
  assign short_o = {1'b0, cnt_q} < lo;
  assign long_o  = {1'b0, cnt_inc} > hi;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_inc;
    if (clear_i)        cnt_d = 8'd0;
    else if (restart_i) cnt_d = 8'd1;
    else if (hold_i)    cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/svetofor_phase_monitor.sv
// Decodes the stoplight lamp lines back into a phase, checks phase order
// and dwell times, latches the first fault, counts completed cycles.
module svetofor_phase_monitor
  import svetofor_phase_monitor_pkg::*;
#(
  parameter logic [7:0] RED_TICKS    = DEF_RED_TICKS,
  parameter logic [7:0] REDYEL_TICKS = DEF_REDYEL_TICKS,
  parameter logic [7:0] GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter logic [7:0] BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter logic [7:0] YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter logic [7:0] TOL          = DEF_TOL
) (
  input  logic                     time_signal,
  input  logic                     reset,
  svetofor_phase_monitor_if.slave  mon
);

  logic [2:0]  lamp_q;
  logic [2:0]  lamp_prev_q;
  phase_e      phase_q;
  phase_e      phase_d;
  logic        fault_q;
  logic        fault_d;
  fcode_e      code_q;
  fcode_e      code_d;
  logic [15:0] cyc_q;
  logic [15:0] cyc_d;

  logic        stay;
  logic        leave;
  phase_e      nxt;
  fcode_e      fc;
  logic        active;
  logic        t_clear;
  logic        t_restart;
  logic        t_hold;
  logic [7:0]  exp_sel;
  logic [7:0]  dwell;
  logic        tmr_short;
  logic        tmr_long;

  always_comb begin
    exp_sel = 8'd0;
    unique case (phase_q)
      PH_RED:    exp_sel = RED_TICKS;
      PH_REDYEL: exp_sel = REDYEL_TICKS;
      PH_GREEN:  exp_sel = GREEN_TICKS;
      PH_BLINK:  exp_sel = BLINK_TICKS;
      PH_YELLOW: exp_sel = YELLOW_TICKS;
      default:   exp_sel = 8'd0;
    endcase
  end

  svetofor_dwell_timer u_timer (
    .clk_i     (time_signal),
    .rst_ni    (reset),
    .clear_i   (t_clear),
    .restart_i (t_restart),
    .hold_i    (t_hold),
    .exp_i     (exp_sel),
    .tol_i     (TOL),
    .cnt_o     (dwell),
    .short_o   (tmr_short),
    .long_o    (tmr_long)
  );

  // Which lamp pattern keeps the phase and which one advances it
  always_comb begin
    stay  = 1'b0;
    leave = 1'b0;
    nxt   = phase_q;
    unique case (phase_q)
      PH_RED: begin
        stay  = (lamp_q == LAMP_RED);
        leave = (lamp_q == LAMP_REDYEL);
        nxt   = PH_REDYEL;
      end
      PH_REDYEL: begin
        stay  = (lamp_q == LAMP_REDYEL);
        leave = (lamp_q == LAMP_GREEN);
        nxt   = PH_GREEN;
      end
      PH_GREEN: begin
        stay  = (lamp_q == LAMP_GREEN);
        leave = (lamp_q == LAMP_OFF);
        nxt   = PH_BLINK;
      end
      PH_BLINK: begin
        stay  = (lamp_q == LAMP_GREEN) ||
                (lamp_q == LAMP_OFF);
        leave = (lamp_q == LAMP_YELLOW);
        nxt   = PH_YELLOW;
      end
      PH_YELLOW: begin
        stay  = (lamp_q == LAMP_YELLOW);
        leave = (lamp_q == LAMP_RED);
        nxt   = PH_RED;
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    fault_d   = fault_q;
    code_d    = code_q;
    cyc_d     = cyc_q;
    fc        = FC_NONE;
    t_clear   = 1'b0;
    t_restart = 1'b0;
    t_hold    = 1'b0;
    active    = (phase_q != PH_SYNC) &&
                (phase_q != PH_FAULT);

    if (active) begin
      if (!lamp_legal(lamp_q)) begin
        fc = FC_PATTERN;
      end else if (stay) begin
        if (tmr_long) fc = FC_LONG;
      end else if (leave) begin
        if (tmr_short) fc = FC_SHORT;
      end else begin
        fc = FC_TRANS;
      end
    end

    // A fresh fault beats fault_clr; an overrun keeps the count it hit
    if (fc != FC_NONE) begin
      phase_d = PH_FAULT;
      fault_d = 1'b1;
      code_d  = fc;
      t_hold  = (fc != FC_LONG);
    end else if (mon.fault_clr) begin
      phase_d = PH_SYNC;
      fault_d = 1'b0;
      code_d  = FC_NONE;
      t_clear = 1'b1;
    end else if (phase_q == PH_FAULT) begin
      t_hold = 1'b1;
    end else if (phase_q == PH_SYNC) begin
      if (lamp_prev_q == LAMP_RED &&
          lamp_q == LAMP_REDYEL) begin
        phase_d   = PH_REDYEL;
        t_restart = 1'b1;
      end else begin
        t_clear = 1'b1;
      end
    end else if (leave) begin
      phase_d   = nxt;
      t_restart = 1'b1;
      if (phase_q == PH_YELLOW) cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge time_signal or negedge reset) begin
    if (!reset) begin
      lamp_q      <= LAMP_OFF;
      lamp_prev_q <= LAMP_OFF;
      phase_q     <= PH_SYNC;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      cyc_q       <= 16'd0;
    end else begin
      lamp_q      <= {mon.green, mon.yellow, mon.red};
      lamp_prev_q <= lamp_q;
      phase_q     <= phase_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      cyc_q       <= cyc_d;
    end
  end

  assign mon.phase       = phase_q;
  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.dwell       = dwell;
  assign mon.cycle_count = cyc_q;
  assign mon.ped_walk    = (phase_q == PH_RED);
  assign mon.ped_stop    = (phase_q != PH_RED);

endmodule

// File: tb/tb_svetofor_phase_monitor.sv
// Directed bench for the stoplight phase monitor.
module tb_svetofor_phase_monitor;

  localparam logic [2:0] R  = 3'b110;
  localparam logic [2:0] RY = 3'b100;
  localparam logic [2:0] G  = 3'b011;
  localparam logic [2:0] O  = 3'b111;
  localparam logic [2:0] Y  = 3'b101;

  logic time_signal;
  logic reset;
  int   n_assert;
  int   n_fail;

  svetofor_phase_monitor_if mon ();

  svetofor_phase_monitor dut (
    .time_signal (time_signal),
    .reset       (reset),
    .mon         (mon)
  );

  initial time_signal = 1'b0;
  always #5 time_signal = ~time_signal;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    {mon.green, mon.yellow, mon.red} = p;
    repeat (n) @(posedge time_signal);
    #1;
  endtask

  task automatic clr_pulse(input logic [2:0] p);
    mon.fault_clr = 1'b1;
    {mon.green, mon.yellow, mon.red} = p;
    @(posedge time_signal);
    #1;
    mon.fault_clr = 1'b0;
  endtask

  task automatic blink8();
    for (int i = 0; i < 4; i++) begin
      hold(O, 1);
      hold(G, 1);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    mon.fault_clr = 1'b0;
    {mon.green, mon.yellow, mon.red} = O;
    repeat (2) @(posedge time_signal);
    #1;
    chk("rst_phase", mon.phase, 0);
    chk("rst_fault", mon.fault, 0);
    chk("rst_code", mon.fault_code, 0);
    chk("rst_dwell", mon.dwell, 0);
    chk("rst_cyc", mon.cycle_count, 0);
    chk("rst_walk", mon.ped_walk, 0);
    chk("rst_stop", mon.ped_stop, 1);
    reset = 1'b1;

    // nominal cycle
    hold(R, 168);
    chk("sync_phase", mon.phase, 0);
    chk("sync_dwell", mon.dwell, 0);
    hold(RY, 6);
    chk("ry_phase", mon.phase, 2);
    chk("ry_dwell", mon.dwell, 5);
    hold(G, 52);
    chk("g_phase", mon.phase, 3);
    chk("g_dwell", mon.dwell, 51);
    hold(O, 1);
    hold(G, 1);
    chk("bl_phase", mon.phase, 4);
    chk("bl_dwell1", mon.dwell, 1);
    for (int i = 0; i < 3; i++) begin
      hold(O, 1);
      hold(G, 1);
    end
    chk("bl_dwell7", mon.dwell, 7);
    hold(Y, 6);
    chk("y_phase", mon.phase, 5);
    chk("y_dwell", mon.dwell, 5);
    hold(R, 2);
    chk("r_phase", mon.phase, 1);
    chk("r_dwell", mon.dwell, 1);
    chk("cyc1", mon.cycle_count, 1);
    chk("r_walk", mon.ped_walk, 1);
    chk("r_stop", mon.ped_stop, 0);
    hold(R, 166);
    chk("r_dwell167", mon.dwell, 167);
    chk("nom_fault", mon.fault, 0);

    // red+green glitch in GREEN
    hold(RY, 6);
    hold(G, 10);
    chk("g2_dwell", mon.dwell, 9);
    hold(3'b010, 1);
    chk("glitch_e1_fault", mon.fault, 0);
    hold(G, 1);
    chk("glitch_fault", mon.fault, 1);
    chk("glitch_code", mon.fault_code, 1);
    chk("glitch_phase", mon.phase, 7);
    chk("glitch_dwell", mon.dwell, 10);
    hold(Y, 3);
    chk("first_code_kept", mon.fault_code, 1);

    // clear and resync
    clr_pulse(R);
    chk("clr_phase", mon.phase, 0);
    chk("clr_fault", mon.fault, 0);
    chk("clr_code", mon.fault_code, 0);
    chk("clr_dwell", mon.dwell, 0);
    chk("clr_cyc", mon.cycle_count, 1);
    hold(R, 20);
    chk("resync_wait", mon.phase, 0);
    hold(RY, 6);
    chk("resync_phase", mon.phase, 2);

    // GREEN overrun
    hold(G, 55);
    chk("g_edge_dwell", mon.dwell, 54);
    chk("g_edge_fault", mon.fault, 0);
    hold(G, 1);
    chk("long_code", mon.fault_code, 4);
    chk("long_phase", mon.phase, 7);
    chk("long_dwell", mon.dwell, 55);
    hold(G, 4);
    chk("long_dwell_hold", mon.dwell, 55);

    // short YELLOW
    clr_pulse(R);
    hold(R, 10);
    hold(RY, 6);
    hold(G, 52);
    blink8();
    hold(Y, 3);
    hold(R, 1);
    chk("ys_phase", mon.phase, 5);
    chk("ys_dwell", mon.dwell, 3);
    hold(R, 1);
    chk("short_code", mon.fault_code, 3);
    chk("short_phase", mon.phase, 7);
    chk("short_dwell", mon.dwell, 3);
    chk("short_cyc", mon.cycle_count, 1);

    // reset in mid-BLINK
    clr_pulse(R);
    hold(R, 5);
    hold(RY, 6);
    hold(G, 52);
    hold(O, 1);
    hold(G, 1);
    hold(O, 1);
    chk("pre_rst_phase", mon.phase, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_phase", mon.phase, 0);
    chk("mr_fault", mon.fault, 0);
    chk("mr_code", mon.fault_code, 0);
    chk("mr_dwell", mon.dwell, 0);
    chk("mr_cyc", mon.cycle_count, 0);
    chk("mr_walk", mon.ped_walk, 0);
    chk("mr_stop", mon.ped_stop, 1);
    #4;
    reset = 1'b1;
    hold(O, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
